// File: rtl/distributor_2bits_pkg.sv
// Shared slot arithmetic and defaults for the 1:4 byte distributor.
`default_nettype none

package distributor_2bits_pkg;

  localparam int SLOT_W        = 2;
  localparam int NSLOTS        = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NSLOTS - 1);

  function automatic logic is_last_slot(input slot_t s);
    return s == LAST_SLOT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/distributor_2bits_slot_counter.sv
// Two-bit write-slot counter with a one-cycle wrap pulse when slot 3 advances to 0.
`default_nettype none

module slot_counter_2bits
  import distributor_2bits_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  EN,
  input  logic  CLR,
  output slot_t counter,
  output logic  OV
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      counter <= '0;
      OV      <= 1'b0;
    end else if (CLR) begin
      counter <= '0;
      OV      <= 1'b0;
    end else begin
      OV <= EN && is_last_slot(counter);
      if (EN) begin
        counter <= counter + slot_t'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/distributor_2bits.sv
// 1:4 byte distributor: collects four accepted bytes and presents them as one
// parallel group on a valid/ready output handshake.
`default_nettype none

module distributor_2bits
  import distributor_2bits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CLR,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number1,
  output logic [WIDTH-1:0] number2,
  output logic [WIDTH-1:0] number3,
  output logic [WIDTH-1:0] number4,
  output slot_t            slot,
  output logic             OV
);

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] collect0;
  logic [WIDTH-1:0] collect1;
  logic [WIDTH-1:0] collect2;

  assign last = is_last_slot(slot);

  // Only the final byte of a group needs a free output stage; slots 0..2 keep filling.
  assign in_ready = reset && !CLR && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  slot_counter_2bits u_slot_counter (
    .clk     (clk),
    .reset   (reset),
    .EN      (accept),
    .CLR     (CLR),
    .counter (slot),
    .OV      (OV)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      collect0 <= '0;
      collect1 <= '0;
      collect2 <= '0;
    end else if (accept) begin
      case (slot)
        2'd0:    collect0 <= in_data;
        2'd1:    collect1 <= in_data;
        2'd2:    collect2 <= in_data;
        default: ;
      endcase
    end
  end

  // A completing group takes priority over consumption so back-to-back groups keep out_valid high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      number1   <= '0;
      number2   <= '0;
      number3   <= '0;
      number4   <= '0;
      out_valid <= 1'b0;
    end else if (accept && last) begin
      number1   <= collect0;
      number2   <= collect1;
      number3   <= collect2;
      number4   <= in_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_distributor_2bits.sv
// Self-checking bench for distributor_2bits: queue-based model checked every cycle plus directed literals.
`default_nettype none

module tb_distributor_2bits;

  logic       clk = 1'b0;
  logic       reset;
  logic       CLR;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] number1, number2, number3, number4;
  logic [1:0] slot;
  logic       OV;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  distributor_2bits #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .number1   (number1),
    .number2   (number2),
    .number3   (number3),
    .number4   (number4),
    .slot      (slot),
    .OV        (OV)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the partial group is a queue of accepted bytes; its length is the write slot.
  logic [7:0] mpart[$];
  logic [7:0] mnum[4];
  logic       mvalid = 1'b0;
  logic       mov    = 1'b0;

  function automatic logic model_ready();
    return reset && !CLR && !(mpart.size() == 3 && mvalid && !out_ready);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mpart.delete();
      mvalid = 1'b0;
      mov    = 1'b0;
      for (int i = 0; i < 4; i++) mnum[i] = 8'h00;
    end else begin
      logic acc;
      acc = in_valid && model_ready();
      mov = 1'b0;
      if (mvalid && out_ready) mvalid = 1'b0;
      if (CLR) begin
        mpart.delete();
      end else if (acc) begin
        mpart.push_back(in_data);
        if (mpart.size() == 4) begin
          for (int i = 0; i < 4; i++) mnum[i] = mpart[i];
          mpart.delete();
          mvalid = 1'b1;
          mov    = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  32'(in_ready),  32'(model_ready()));
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      chk("OV",        32'(OV),        32'(mov));
      chk("slot",      32'(slot),      32'(mpart.size()));
      chk("number1",   32'(number1),   32'(mnum[0]));
      chk("number2",   32'(number2),   32'(mnum[1]));
      chk("number3",   32'(number3),   32'(mnum[2]));
      chk("number4",   32'(number4),   32'(mnum[3]));
    end
  end

  // Loopback: a 4:1 selector stepping slots 0..3 re-serialises every consumed group.
  logic [7:0] serial_q[$];
  always @(posedge clk) begin
    if (reset && out_valid && out_ready) begin
      serial_q.push_back(number1);
      serial_q.push_back(number2);
      serial_q.push_back(number3);
      serial_q.push_back(number4);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      cyc();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted within 40 cycles", b);
    end
  endtask

  task automatic chk_group(input string name, input logic [31:0] exp);
    chk(name, {number1, number2, number3, number4}, exp);
  endtask

  logic [7:0] exp_serial[20];

  initial begin
    exp_serial = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
                   8'h15, 8'h16, 8'h17, 8'h18, 8'h31, 8'h32, 8'h33, 8'h34,
                   8'h51, 8'h52, 8'h53, 8'h54};
    reset = 1'b0; CLR = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // 1: reset held 3 cycles
    cyc();
    cmp_en = 1'b1;
    cyc(); cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_group("rst_group", 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_slot", 32'(slot), 32'd0);

    // 2: basic group with consumer ready
    out_ready = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    in_valid = 1'b0;
    chk_group("t2_group", 32'h01020304);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_ov", 32'(OV), 32'd1);
    cyc();
    chk("t2_ov_drop", 32'(OV), 32'd0);
    chk("t2_valid_drop", 32'(out_valid), 32'd0);

    // 3: backpressure, collection continues to slot 3 then stalls
    out_ready = 1'b0;
    for (int b = 8'h11; b <= 8'h17; b++) send(8'(b));
    in_data = 8'h18;
    cyc(); cyc();
    chk_group("t3_hold", 32'h11121314);
    chk("t3_slot", 32'(slot), 32'd3);
    chk("t3_stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(8'h18);
    in_valid = 1'b0;
    chk_group("t3_next", 32'h15161718);
    chk("t3_valid_kept", 32'(out_valid), 32'd1);
    cyc();

    // 4: CLR discards a partial group and blocks the byte offered alongside it
    send(8'h21); send(8'h22);
    CLR = 1'b1; in_valid = 1'b1; in_data = 8'h23;
    #1;
    chk("t4_clr_ready", 32'(in_ready), 32'd0);
    cyc();
    CLR = 1'b0; in_valid = 1'b0;
    chk("t4_slot", 32'(slot), 32'd0);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    in_valid = 1'b0;
    chk_group("t4_group", 32'h31323334);
    cyc();

    // 5: reset mid-group
    send(8'h41); send(8'h42);
    in_valid = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_slot", 32'(slot), 32'd0);
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    in_valid = 1'b0;
    chk_group("t5_group", 32'h51525354);
    cyc(); cyc();

    // 6: loopback order
    chk("lb_len", 32'(serial_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < serial_q.size(); i++) begin
      chk($sformatf("lb_byte%0d", i), 32'(serial_q[i]), 32'(exp_serial[i]));
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
